// File: rtl/ioctl_region_loader.sv
// Download engine: maps an HPS ioctl download onto one of REGIONS memory windows,
// packs bytes into words, buffers them in a small FIFO and writes them out over req/ack.
module ioctl_region_loader #(
  parameter int REGIONS    = 4,
  parameter int ADDR_W     = 20,
  parameter int WORD_BYTES = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      ioctl_download,
  input  logic [7:0]                ioctl_index,
  input  logic                      ioctl_wr,
  input  logic [24:0]               ioctl_addr,
  input  logic [7:0]                ioctl_data,
  output logic                      ioctl_wait,
  input  logic [8*REGIONS-1:0]      region_index,
  input  logic [ADDR_W*REGIONS-1:0] region_base,
  input  logic [ADDR_W*REGIONS-1:0] region_size,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [8*WORD_BYTES-1:0]   mem_data,
  output logic [WORD_BYTES-1:0]     mem_be,
  input  logic                      mem_ack,
  output logic                      busy,
  output logic                      hold_reset,
  output logic                      done,
  output logic [REGIONS-1:0]        overflow,
  output logic [2:0]                active_region
);

  localparam int DW = 8 * WORD_BYTES;
  localparam int LW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(WORD_BYTES - 1);
  localparam logic [LW-1:0]     LAST_LANE = LW'(WORD_BYTES - 1);

  logic [1:0]            state_q, state_d;
  logic                  discard_q, discard_d;
  logic [2:0]            region_q, region_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [ADDR_W-1:0]     size_q, size_d;
  logic [REGIONS-1:0]    overflow_q, overflow_d;
  logic                  busy_q, done_q, wait_q, wait_d, mem_req_q;

  logic                  acc_v_q, acc_v_d;
  logic [ADDR_W-1:0]     acc_addr_q, acc_addr_d;
  logic [DW-1:0]         acc_data_q, acc_data_d;
  logic [WORD_BYTES-1:0] acc_be_q, acc_be_d;

  // Two push slots: a word-address jump can flush the old partial word and complete a new one together.
  logic                  p0_v_q, p0_v_d, p1_v_q, p1_v_d;
  logic [ADDR_W-1:0]     p0_addr_q, p0_addr_d, p1_addr_q, p1_addr_d;
  logic [DW-1:0]         p0_data_q, p0_data_d, p1_data_q, p1_data_d;
  logic [WORD_BYTES-1:0] p0_be_q, p0_be_d, p1_be_q, p1_be_d;

  logic [ADDR_W-1:0]     f_addr_q [FIFO_DEPTH];
  logic [DW-1:0]         f_data_q [FIFO_DEPTH];
  logic [WORD_BYTES-1:0] f_be_q   [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d, npush_s;
  logic [CW:0]           occ_s;
  logic                  pop_s;

  logic                  match_found_s;
  logic [2:0]            match_idx_s;
  logic [ADDR_W-1:0]     match_base_s, match_size_s;
  logic                  byte_en_s, in_range_s, same_word_s;
  logic [LW-1:0]         lane_s;
  logic [ADDR_W-1:0]     waddr_s;
  logic [DW-1:0]         byte_word_s, cur_data_s;
  logic [WORD_BYTES-1:0] byte_be_s, cur_be_s;

  always_comb begin
    match_found_s = 1'b0;
    match_idx_s   = 3'd0;
    match_base_s  = {ADDR_W{1'b0}};
    match_size_s  = {ADDR_W{1'b0}};
    for (int i = REGIONS - 1; i >= 0; i--) begin
      if (region_index[8*i +: 8] == ioctl_index) begin
        match_found_s = 1'b1;
        match_idx_s   = 3'(i);
        match_base_s  = region_base[ADDR_W*i +: ADDR_W];
        match_size_s  = region_size[ADDR_W*i +: ADDR_W];
      end else begin
        match_found_s = match_found_s;
      end
    end
  end

  always_comb begin
    byte_en_s   = (state_q == ST_LOAD) && ioctl_download && ioctl_wr && !discard_q;
    in_range_s  = ({7'd0, ioctl_addr} < 32'(size_q));
    lane_s      = (WORD_BYTES == 1) ? {LW{1'b0}} : ioctl_addr[LW-1:0];
    waddr_s     = base_q + (ioctl_addr[ADDR_W-1:0] & ~LANE_MASK);
    byte_word_s = DW'(ioctl_data) << {lane_s, 3'b000};
    byte_be_s   = WORD_BYTES'(1'b1) << lane_s;
    same_word_s = acc_v_q && (acc_addr_q == waddr_s);
    cur_data_s  = (same_word_s ? acc_data_q : {DW{1'b0}}) | byte_word_s;
    cur_be_s    = (same_word_s ? acc_be_q : {WORD_BYTES{1'b0}}) | byte_be_s;
  end

  always_comb begin
    pop_s   = mem_req_q && mem_ack;
    npush_s = CW'(p0_v_q) + CW'(p1_v_q);
    count_d = count_q + npush_s - CW'(pop_s);
  end

  always_comb begin
    state_d    = state_q;
    discard_d  = discard_q;
    region_d   = region_q;
    base_d     = base_q;
    size_d     = size_q;
    overflow_d = overflow_q;
    acc_v_d    = acc_v_q;
    acc_addr_d = acc_addr_q;
    acc_data_d = acc_data_q;
    acc_be_d   = acc_be_q;
    p0_v_d     = 1'b0;
    p0_addr_d  = p0_addr_q;
    p0_data_d  = p0_data_q;
    p0_be_d    = p0_be_q;
    p1_v_d     = 1'b0;
    p1_addr_d  = p1_addr_q;
    p1_data_d  = p1_data_q;
    p1_be_d    = p1_be_q;
    case (state_q)
      ST_IDLE: begin
        if (ioctl_download) begin
          state_d   = ST_LOAD;
          discard_d = !match_found_s;
          region_d  = match_idx_s;
          base_d    = match_base_s;
          size_d    = match_size_s;
          acc_v_d   = 1'b0;
          for (int r = 0; r < REGIONS; r++) begin
            if (match_found_s && (match_idx_s == 3'(r))) overflow_d[r] = 1'b0;
            else overflow_d[r] = overflow_q[r];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (!ioctl_download) begin
          state_d   = ST_DRAIN;
          p0_v_d    = acc_v_q;
          p0_addr_d = acc_addr_q;
          p0_data_d = acc_data_q;
          p0_be_d   = acc_be_q;
          acc_v_d   = 1'b0;
        end else if (byte_en_s && !in_range_s) begin
          for (int r = 0; r < REGIONS; r++) begin
            if (region_q == 3'(r)) overflow_d[r] = 1'b1;
            else overflow_d[r] = overflow_q[r];
          end
        end else if (byte_en_s) begin
          if (acc_v_q && !same_word_s) begin
            p0_v_d    = 1'b1;
            p0_addr_d = acc_addr_q;
            p0_data_d = acc_data_q;
            p0_be_d   = acc_be_q;
          end else begin
            p0_v_d = 1'b0;
          end
          if (lane_s == LAST_LANE) begin
            acc_v_d = 1'b0;
            if (acc_v_q && !same_word_s) begin
              p1_v_d    = 1'b1;
              p1_addr_d = waddr_s;
              p1_data_d = cur_data_s;
              p1_be_d   = cur_be_s;
            end else begin
              p0_v_d    = 1'b1;
              p0_addr_d = waddr_s;
              p0_data_d = cur_data_s;
              p0_be_d   = cur_be_s;
            end
          end else begin
            acc_v_d    = 1'b1;
            acc_addr_d = waddr_s;
            acc_data_d = cur_data_s;
            acc_be_d   = cur_be_s;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (count_d == {CW{1'b0}}) state_d = ST_DONE;
        else state_d = ST_DRAIN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Wait counts words already queued plus those in flight, so a late byte still finds a slot.
  always_comb begin
    occ_s  = (CW+1)'(count_d) + (CW+1)'(p0_v_d) + (CW+1)'(p1_v_d);
    wait_d = (occ_s >= (CW+1)'(FIFO_DEPTH - 1));
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      discard_q  <= 1'b0;
      region_q   <= 3'd0;
      base_q     <= {ADDR_W{1'b0}};
      size_q     <= {ADDR_W{1'b0}};
      overflow_q <= {REGIONS{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wait_q     <= 1'b0;
      acc_v_q    <= 1'b0;
      acc_addr_q <= {ADDR_W{1'b0}};
      acc_data_q <= {DW{1'b0}};
      acc_be_q   <= {WORD_BYTES{1'b0}};
      p0_v_q     <= 1'b0;
      p0_addr_q  <= {ADDR_W{1'b0}};
      p0_data_q  <= {DW{1'b0}};
      p0_be_q    <= {WORD_BYTES{1'b0}};
      p1_v_q     <= 1'b0;
      p1_addr_q  <= {ADDR_W{1'b0}};
      p1_data_q  <= {DW{1'b0}};
      p1_be_q    <= {WORD_BYTES{1'b0}};
    end else begin
      state_q    <= state_d;
      discard_q  <= discard_d;
      region_q   <= region_d;
      base_q     <= base_d;
      size_q     <= size_d;
      overflow_q <= overflow_d;
      busy_q     <= (state_d == ST_LOAD) || (state_d == ST_DRAIN);
      done_q     <= (state_d == ST_DONE);
      wait_q     <= wait_d;
      acc_v_q    <= acc_v_d;
      acc_addr_q <= acc_addr_d;
      acc_data_q <= acc_data_d;
      acc_be_q   <= acc_be_d;
      p0_v_q     <= p0_v_d;
      p0_addr_q  <= p0_addr_d;
      p0_data_q  <= p0_data_d;
      p0_be_q    <= p0_be_d;
      p1_v_q     <= p1_v_d;
      p1_addr_q  <= p1_addr_d;
      p1_data_q  <= p1_data_d;
      p1_be_q    <= p1_be_d;
    end
  end

  // Word FIFO; slot p1 only ever follows p0, so it lands one entry behind it.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      count_q   <= {CW{1'b0}};
      mem_req_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        f_addr_q[i] <= {ADDR_W{1'b0}};
        f_data_q[i] <= {DW{1'b0}};
        f_be_q[i]   <= {WORD_BYTES{1'b0}};
      end
    end else begin
      if (p0_v_q) begin
        f_addr_q[wr_ptr_q] <= p0_addr_q;
        f_data_q[wr_ptr_q] <= p0_data_q;
        f_be_q[wr_ptr_q]   <= p0_be_q;
      end
      if (p1_v_q) begin
        f_addr_q[wr_ptr_q + PW'(1'b1)] <= p1_addr_q;
        f_data_q[wr_ptr_q + PW'(1'b1)] <= p1_data_q;
        f_be_q[wr_ptr_q + PW'(1'b1)]   <= p1_be_q;
      end
      wr_ptr_q  <= wr_ptr_q + PW'(npush_s);
      rd_ptr_q  <= rd_ptr_q + PW'(pop_s);
      count_q   <= count_d;
      mem_req_q <= (count_d != {CW{1'b0}});
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_addr      = f_addr_q[rd_ptr_q];
  assign mem_data      = f_data_q[rd_ptr_q];
  assign mem_be        = f_be_q[rd_ptr_q];
  assign ioctl_wait    = wait_q;
  assign busy          = busy_q;
  assign hold_reset    = busy_q;
  assign done          = done_q;
  assign overflow      = overflow_q;
  assign active_region = region_q;

endmodule

// File: tb/tb_ioctl_region_loader.sv
// Scoreboard bench for ioctl_region_loader: expected writes are queued as bytes are driven
// and compared in order as the memory side accepts them.
module tb_ioctl_region_loader;
  localparam int REGIONS = 4;
  localparam int ADDR_W  = 20;
  localparam int WB      = 2;
  localparam int DEPTH   = 4;

  logic                      clk_sys = 1'b0;
  logic                      reset;
  logic                      ioctl_download;
  logic [7:0]                ioctl_index;
  logic                      ioctl_wr;
  logic [24:0]               ioctl_addr;
  logic [7:0]                ioctl_data;
  logic                      ioctl_wait;
  logic [8*REGIONS-1:0]      region_index;
  logic [ADDR_W*REGIONS-1:0] region_base;
  logic [ADDR_W*REGIONS-1:0] region_size;
  logic                      mem_req;
  logic [ADDR_W-1:0]         mem_addr;
  logic [8*WB-1:0]           mem_data;
  logic [WB-1:0]             mem_be;
  logic                      mem_ack;
  logic                      busy, hold_reset, done;
  logic [REGIONS-1:0]        overflow;
  logic [2:0]                active_region;

  ioctl_region_loader #(.REGIONS(REGIONS), .ADDR_W(ADDR_W), .WORD_BYTES(WB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
    .region_index(region_index), .region_base(region_base), .region_size(region_size),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be), .mem_ack(mem_ack),
    .busy(busy), .hold_reset(hold_reset), .done(done), .overflow(overflow), .active_region(active_region)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [8*WB-1:0]   data;
    logic [WB-1:0]     be;
  } wr_t;

  wr_t exp_q[$];
  int  err_cnt = 0;
  int  chk_cnt = 0;
  int  cyc = 0;
  int  last_ack_cyc = 0;
  int  done_cyc = 0;
  int  done_cnt = 0;
  bit  wait_seen = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Memory-side monitor: pops the scoreboard on every accepted write and watches done/wait.
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (ioctl_wait) wait_seen = 1'b1;
      if (mem_req && mem_ack) begin
        wr_t e;
        last_ack_cyc = cyc;
        if (exp_q.size() == 0) begin
          check_val("write_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_val("mem_addr", 32'(mem_addr), 32'(e.addr));
          check_val("mem_data", 32'(mem_data), 32'(e.data));
          check_val("mem_be", 32'(mem_be), 32'(e.be));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check_val("busy_at_done", 32'(busy), 0);
        check_val("hold_at_done", 32'(hold_reset), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_region(input int r, input logic [7:0] idx, input logic [ADDR_W-1:0] base,
                            input logic [ADDR_W-1:0] size);
    region_index[8*r +: 8]         = idx;
    region_base[ADDR_W*r +: ADDR_W] = base;
    region_size[ADDR_W*r +: ADDR_W] = size;
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [8*WB-1:0] d, input logic [WB-1:0] be);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.be   = be;
    exp_q.push_back(e);
  endtask

  task automatic start_load(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int n = 0;
    while (ioctl_wait && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check_val("wait_release", n, 0);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_data = d;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic end_load(input string tag);
    int start = done_cnt;
    int n = 0;
    ioctl_download = 1'b0;
    while (done_cnt == start && n < 200) begin
      tick();
      n++;
    end
    check_val({tag, "_done"}, done_cnt - start, 1);
    check_val({tag, "_drained"}, exp_q.size(), 0);
    tick();
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'h00; ioctl_wr = 1'b0;
    ioctl_addr = 25'd0; ioctl_data = 8'h00; mem_ack = 1'b1;
    region_index = '0; region_base = '0; region_size = '0;
    set_region(0, 8'h00, 20'h08000, 20'h04000);
    set_region(1, 8'h07, 20'h01000, 20'h00100);
    set_region(2, 8'h07, 20'h02000, 20'h00100);
    set_region(3, 8'h09, 20'h03000, 20'h00100);
    repeat (3) tick();
    check_val("rst_mem_req", 32'(mem_req), 0);
    check_val("rst_wait", 32'(ioctl_wait), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_hold", 32'(hold_reset), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_overflow", 32'(overflow), 0);
    check_val("rst_region", 32'(active_region), 0);
    check_val("rst_mem_addr", 32'(mem_addr), 0);
    check_val("rst_mem_data", 32'(mem_data), 0);
    check_val("rst_mem_be", 32'(mem_be), 0);
    reset = 1'b0;
    tick();

    // Basic 4-byte load, done one cycle after the last ack.
    push_exp(20'h08000, 16'h2211, 2'b11);
    push_exp(20'h08002, 16'h4433, 2'b11);
    start_load(8'h00);
    check_val("t1_busy", 32'(busy), 1);
    check_val("t1_hold", 32'(hold_reset), 1);
    check_val("t1_region", 32'(active_region), 0);
    send_byte(25'd0, 8'h11);
    send_byte(25'd1, 8'h22);
    send_byte(25'd2, 8'h33);
    send_byte(25'd3, 8'h44);
    end_load("t1");
    check_val("t1_done_lat", done_cyc, last_ack_cyc + 1);

    // Odd length: trailing partial word.
    push_exp(20'h08000, 16'hBBAA, 2'b11);
    push_exp(20'h08002, 16'h00CC, 2'b01);
    start_load(8'h00);
    send_byte(25'd0, 8'hAA);
    send_byte(25'd1, 8'hBB);
    send_byte(25'd2, 8'hCC);
    end_load("t2");

    // Unmatched index: bytes swallowed, no writes, no wait.
    wait_seen = 1'b0;
    start_load(8'h05);
    for (int i = 0; i < 16; i++) send_byte(25'(i), 8'(i + 8'h40));
    end_load("t3");
    check_val("t3_wait", 32'(wait_seen), 0);

    // Region size limit sets overflow.
    set_region(0, 8'h00, 20'h08000, 20'h00002);
    push_exp(20'h08000, 16'h2211, 2'b11);
    start_load(8'h00);
    for (int i = 0; i < 4; i++) send_byte(25'(i), 8'((i + 1) * 8'h11));
    end_load("t4");
    check_val("t4_overflow", 32'(overflow), 32'h1);
    set_region(0, 8'h00, 20'h08000, 20'h04000);

    // Lowest matching region wins; overflow of another region is untouched.
    push_exp(20'h01000, 16'h6655, 2'b11);
    start_load(8'h07);
    check_val("t5_region", 32'(active_region), 1);
    check_val("t5_overflow_sticky", 32'(overflow), 32'h1);
    send_byte(25'd0, 8'h55);
    send_byte(25'd1, 8'h66);
    end_load("t5");

    // Word jump: partial flush and completed new word in one cycle.
    push_exp(20'h08000, 16'h005A, 2'b01);
    push_exp(20'h08002, 16'hC300, 2'b10);
    start_load(8'h00);
    check_val("t6_overflow_clr", 32'(overflow), 0);
    send_byte(25'd0, 8'h5A);
    send_byte(25'd3, 8'hC3);
    end_load("t6");

    // Backpressure: ack held low for 20 cycles while 16 bytes stream.
    mem_ack = 1'b0;
    wait_seen = 1'b0;
    for (int i = 0; i < 8; i++)
      push_exp(20'h08000 + 20'(2 * i), {8'(2 * i + 1 + 8'h80), 8'(2 * i + 8'h80)}, 2'b11);
    fork
      begin
        repeat (20) @(posedge clk_sys);
        #1 mem_ack = 1'b1;
      end
    join_none
    start_load(8'h00);
    for (int i = 0; i < 16; i++) send_byte(25'(i), 8'(i + 8'h80));
    end_load("t7");
    check_val("t7_wait_seen", 32'(wait_seen), 1);

    // Reset in the middle of a load with two words queued.
    mem_ack = 1'b0;
    start_load(8'h00);
    for (int i = 0; i < 4; i++) send_byte(25'(i), 8'(i + 8'hE0));
    tick();
    tick();
    check_val("t8_queued_req", 32'(mem_req), 1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    tick();
    reset = 1'b0;
    check_val("t8_req", 32'(mem_req), 0);
    check_val("t8_busy", 32'(busy), 0);
    check_val("t8_hold", 32'(hold_reset), 0);
    check_val("t8_wait", 32'(ioctl_wait), 0);
    mem_ack = 1'b1;
    tick();
    check_val("t8_fifo_cleared", 32'(mem_req), 0);
    push_exp(20'h08000, 16'h0201, 2'b11);
    push_exp(20'h08002, 16'h0403, 2'b11);
    start_load(8'h00);
    for (int i = 0; i < 4; i++) send_byte(25'(i), 8'(i + 1));
    end_load("t8");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/ioctl_region_loader.md
# ioctl_region_loader

Parametrised download engine between the HPS `ioctl_*` download bus and the core's memory write port. It replaces the fixed single-ROM byte load with a table of N index-selected regions. Each region has its own base and size. Bytes are packed into WORD_BYTES-wide words and buffered in a small FIFO, and the memory side uses a req/ack handshake with backpressure to HPS via `ioctl_wait`. It also drives a CPU hold-reset while a load is in flight and pulses `done` when the last word has been committed.

## Interface
- REGIONS, 4, number of index-mapped regions (1..8)
- ADDR_W, 20, memory byte-address width
- WORD_BYTES, 2, bytes per memory word (1, 2 or 4)
- FIFO_DEPTH, 4, word FIFO entries (power of 2, ≥2)

- clk_sys  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- ioctl_download  in  1  download window
- ioctl_index  in  8  download slot index
- ioctl_wr  in  1  byte strobe, one cycle per byte
- ioctl_addr  in  25  byte offset within download
- ioctl_data  in  8  byte data
- ioctl_wait  out  1  backpressure to HPS
- region_index  in  8*REGIONS  index value per region
- region_base  in  ADDR_W*REGIONS  byte base per region (word-aligned)
- region_size  in  ADDR_W*REGIONS  byte limit per region
- mem_req  out  1  write request, held until ack
- mem_addr  out  ADDR_W  word-aligned byte address
- mem_data  out  8*WORD_BYTES  write data, byte 0 in bits [7:0]
- mem_be  out  WORD_BYTES  byte enables
- mem_ack  in  1  accepts current word
- busy  out  1  high from LOAD entry to end of DRAIN
- hold_reset  out  1  equals busy; feeds core reset OR
- done  out  1  one-cycle pulse on completion
- overflow  out  REGIONS  sticky per region; bytes dropped beyond size
- active_region  out  3  region latched for current load

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
- **IDLE, download rises:**
  - Latch `ioctl_index` and compare against all `region_index` entries.
  - The lowest-numbered match wins. That region is latched, and its base and size are frozen.
  - If no region matches, enter LOAD with the discard flag set: bytes are consumed, `ioctl_wait` stays 0, and no memory writes occur.
- **LOAD, accepting bytes:**
  - A byte is accepted when `ioctl_wr=1` and `ioctl_download=1`.
  - If `ioctl_addr ≥ size`, the byte is dropped and `overflow[r]` is set.
  - Otherwise lane = `ioctl_addr[log2(WB)-1:0]` and word address = base + (`ioctl_addr` with lane bits cleared).
- **Packing:**
  - The accumulator holds data, the byte-enable mask and the word address.
  - A new byte whose word address differs from the held one first flushes the held partial word, then starts a new accumulator.
  - A byte in lane WB-1 flushes its completed word in the same cycle.
  - WORD_BYTES=1 flushes every byte.
- **LOAD → DRAIN:** on download fall. Any partial accumulator is flushed with its partial `mem_be`.
- **DRAIN → DONE:** when the FIFO is empty and no request is outstanding.
- **DONE:** pulse `done`, then return to IDLE.
- `overflow` clears only on reset or on the next download rise for that region.
- A download rise in DRAIN/DONE is held off: the loader returns to IDLE first, then samples the new download.
- **Write engine:**
  - The FIFO head drives `mem_addr/mem_data/mem_be` with `mem_req=1`.
  - On `mem_ack` the entry pops. If another entry is present, `mem_req` stays high with the new word on the next cycle; otherwise it drops.
- `ioctl_wait=1` when FIFO count ≥ FIFO_DEPTH-1 (one slot reserved for a simultaneous flush-plus-new-word).
- A push and a pop in the same cycle leave the count unchanged. A push into a full FIFO cannot occur by construction.

## Timing
- Reset values:
  - State IDLE.
  - `mem_req`, `ioctl_wait`, `busy`, `hold_reset`, `done` all 0.
  - `overflow` = 0, `active_region` = 0.
  - FIFO empty; `mem_addr`, `mem_data`, `mem_be` = 0.
- Reset mid-load drops `mem_req` in the next cycle and discards the FIFO contents; the memory side tolerates an abandoned request.
- `busy` rises the cycle after the download rise.
- **Flush-to-request latency:**
  - A byte completing a word in cycle N gives a FIFO push at N+1.
  - `mem_req` is high at N+2 if the FIFO was empty.
- Sustained throughput is 1 word/cycle with `mem_ack` tied high.
- `done` pulses 1 cycle after the final ack. `busy/hold_reset` fall in the same cycle as `done`.
- `ioctl_wait` is registered and asserts the cycle after the threshold is reached. HPS may deliver one further byte, which the reserved slot absorbs.

## Test plan
- WB=2, region0 index 0x00, base 0x8000, size 0x4000; 4 bytes 11,22,33,44 at addr 0..3 with ack tied high -> writes (0x8000, 0x2211, be 11) and (0x8002, 0x4433, be 11); `done` 1 cycle after the 2nd ack.
- Odd-length load of 3 bytes AA,BB,CC -> final write at 0x8002 with data 0x00CC, be 01.
- Index 0x05 matches no region; 16 bytes -> no `mem_req`, `ioctl_wait` stays 0, `done` still pulses.
- Region size 0x0002 with 4 bytes -> only 0x8000 written, `overflow[0]`=1.
- `mem_ack` held low for 20 cycles while bytes stream -> `ioctl_wait` asserts at count 3, no byte lost, all words written in order after ack resumes.
- `reset` asserted mid-LOAD with 2 words queued -> next cycle `mem_req`=0, `busy`=0, `hold_reset`=0, state IDLE; a subsequent download loads correctly.
